alu_seq_ctrl: RTL and testbench

Parametrised ALU instruction sequencer for the microcontroller datapath. It accepts one ALU-class instruction per start handshake. It then drives the bus-transfer control strobes: operand A read, operand B read (register or immediate), ALU result latch, and write-back. It finishes with a one-cycle done pulse. It sits between the instruction decoder and the register file / ALU bus, and adds configurable width, settle delay, immediate mode, illegal-opcode reporting and a start/busy handshake.

---
 rtl/alu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// ALU instruction sequencer: latches one ALU-class instruction per start and
// steps the operand/result bus strobes through a fixed Moore sequence.
module alu_seq_ctrl #(
  parameter int IW     = 16,
  parameter int FW     = 6,
  parameter int SETTLE = 1,
  parameter int IMM_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] instr,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic          pc_inc,
  output logic          src1_oe,
  output logic          alu_a_ld,
  output logic          src2_oe,
  output logic          imm_oe,
  output logic          alu_b_ld,
  output logic          alu_out_ld,
  output logic          alu_out_oe,
  output logic          dst_we,
  output logic [FW-1:0] reg_sel,
  output logic [FW-2:0] imm,
  output logic [2:0]    op_ctl
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LD_A, S_GAP, S_RD_B, S_LD_B, S_EXEC, S_DRV, S_WB, S_DONE
  } state_t;

  localparam logic [2:0] GAP_LOAD = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [2:0]    gap_cnt_q, gap_cnt_d;

  logic [3:0]    opcode;
  logic [3:0]    op_diff;
  logic [FW-1:0] param1;
  logic [FW-1:0] param2;
  logic          legal;
  logic          imm_mode;

  assign opcode   = instr_q[IW-1 -: 4];
  assign param1   = instr_q[2*FW-1:FW];
  assign param2   = instr_q[FW-1:0];
  assign legal    = (opcode >= 4'd9);
  assign imm_mode = (IMM_EN != 0) && param2[FW-1];
  assign op_diff  = opcode - 4'd9;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      gap_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = instr;
          state_d = (instr[IW-1 -: 4] >= 4'd9) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: state_d = S_LD_A;
      S_LD_A: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = (SETTLE == 0) ? S_RD_B : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == 3'd0) begin
          state_d = S_RD_B;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
      S_RD_B:  state_d = S_LD_B;
      S_LD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_DRV;
      S_DRV:   state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode; async reset of the state flops clears every output at once.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    illegal    = (state_q == S_DONE) && !legal;
    pc_inc     = 1'b0;
    src1_oe    = 1'b0;
    alu_a_ld   = 1'b0;
    src2_oe    = 1'b0;
    imm_oe     = 1'b0;
    alu_b_ld   = 1'b0;
    alu_out_ld = 1'b0;
    alu_out_oe = 1'b0;
    dst_we     = 1'b0;
    reg_sel    = '0;
    imm        = (busy && imm_mode) ? param2[FW-2:0] : '0;
    op_ctl     = (busy && legal) ? op_diff[2:0] : 3'd0;
    unique case (state_q)
      S_FETCH: begin
        pc_inc  = 1'b1;
        src1_oe = 1'b1;
        reg_sel = param1;
      end
      S_LD_A: begin
        src1_oe  = 1'b1;
        alu_a_ld = 1'b1;
        reg_sel  = param1;
      end
      S_RD_B, S_LD_B: begin
        src2_oe  = !imm_mode;
        imm_oe   = imm_mode;
        alu_b_ld = (state_q == S_LD_B);
        reg_sel  = imm_mode ? '0 : param2;
      end
      S_EXEC: alu_out_ld = 1'b1;
      S_DRV: begin
        alu_out_oe = 1'b1;
        reg_sel    = param1;
      end
      S_WB: begin
        alu_out_oe = 1'b1;
        dst_we     = 1'b1;
        reg_sel    = param1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: default build (SETTLE=1, IMM_EN=1) and a
// SETTLE=0 / IMM_EN=0 build, checked cycle by cycle against hand tables.
module tb_alu_seq_ctrl;

  // strobe vector: busy done illegal pc_inc src1_oe alu_a_ld src2_oe imm_oe alu_b_ld alu_out_ld alu_out_oe dst_we
  localparam logic [11:0] V_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] V_FETCH = 12'b1001_1000_0000;
  localparam logic [11:0] V_LD_A  = 12'b1000_1100_0000;
  localparam logic [11:0] V_GAP   = 12'b1000_0000_0000;
  localparam logic [11:0] V_RDB_R = 12'b1000_0010_0000;
  localparam logic [11:0] V_LDB_R = 12'b1000_0010_1000;
  localparam logic [11:0] V_RDB_I = 12'b1000_0001_0000;
  localparam logic [11:0] V_LDB_I = 12'b1000_0001_1000;
  localparam logic [11:0] V_EXEC  = 12'b1000_0000_0100;
  localparam logic [11:0] V_DRV   = 12'b1000_0000_0010;
  localparam logic [11:0] V_WB    = 12'b1000_0000_0011;
  localparam logic [11:0] V_DONE  = 12'b1100_0000_0000;
  localparam logic [11:0] V_ILL   = 12'b1110_0000_0000;

  logic clk, rst;
  logic start0, start1;
  logic [15:0] instr0, instr1;

  logic busy0, done0, illegal0, pc_inc0, src1_oe0, alu_a_ld0, src2_oe0, imm_oe0;
  logic alu_b_ld0, alu_out_ld0, alu_out_oe0, dst_we0;
  logic [5:0] reg_sel0;
  logic [4:0] imm0;
  logic [2:0] op_ctl0;

  logic busy1, done1, illegal1, pc_inc1, src1_oe1, alu_a_ld1, src2_oe1, imm_oe1;
  logic alu_b_ld1, alu_out_ld1, alu_out_oe1, dst_we1;
  logic [5:0] reg_sel1;
  logic [4:0] imm1;
  logic [2:0] op_ctl1;

  logic [11:0] vec0, vec1;

  int checks = 0;
  int errors = 0;

  logic [11:0] ev [10];
  logic [5:0]  er [10];

  alu_seq_ctrl #(.IW(16), .FW(6), .SETTLE(1), .IMM_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .instr(instr1),
    .busy(busy1), .done(done1), .illegal(illegal1), .pc_inc(pc_inc1),
    .src1_oe(src1_oe1), .alu_a_ld(alu_a_ld1), .src2_oe(src2_oe1), .imm_oe(imm_oe1),
    .alu_b_ld(alu_b_ld1), .alu_out_ld(alu_out_ld1), .alu_out_oe(alu_out_oe1),
    .dst_we(dst_we1), .reg_sel(reg_sel1), .imm(imm1), .op_ctl(op_ctl1)
  );

  alu_seq_ctrl #(.IW(16), .FW(6), .SETTLE(0), .IMM_EN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .instr(instr0),
    .busy(busy0), .done(done0), .illegal(illegal0), .pc_inc(pc_inc0),
    .src1_oe(src1_oe0), .alu_a_ld(alu_a_ld0), .src2_oe(src2_oe0), .imm_oe(imm_oe0),
    .alu_b_ld(alu_b_ld0), .alu_out_ld(alu_out_ld0), .alu_out_oe(alu_out_oe0),
    .dst_we(dst_we0), .reg_sel(reg_sel0), .imm(imm0), .op_ctl(op_ctl0)
  );

  assign vec0 = {busy0, done0, illegal0, pc_inc0, src1_oe0, alu_a_ld0, src2_oe0, imm_oe0,
                 alu_b_ld0, alu_out_ld0, alu_out_oe0, dst_we0};
  assign vec1 = {busy1, done1, illegal1, pc_inc1, src1_oe1, alu_a_ld1, src2_oe1, imm_oe1,
                 alu_b_ld1, alu_out_ld1, alu_out_oe1, dst_we1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one instruction from IDLE, then compare cycles k+1..k+10 against ev/er.
  task automatic run_seq(input logic use0, input logic [15:0] ins, input logic [4:0] imm_e,
                         input logic [2:0] op_e, input string name);
    logic [11:0] v;
    logic [5:0]  rs;
    logic [4:0]  im;
    logic [2:0]  oc;
    if (use0) begin start0 = 1'b1; instr0 = ins; end
    else      begin start1 = 1'b1; instr1 = ins; end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    instr0 = ~ins; instr1 = ~ins;
    for (int i = 0; i < 10; i++) begin
      v  = use0 ? vec0 : vec1;
      rs = use0 ? reg_sel0 : reg_sel1;
      im = use0 ? imm0 : imm1;
      oc = use0 ? op_ctl0 : op_ctl1;
      chk($sformatf("%s c%0d strobes", name, i + 1), 32'(v), 32'(ev[i]));
      chk($sformatf("%s c%0d reg_sel", name, i + 1), 32'(rs), 32'(er[i]));
      chk($sformatf("%s c%0d imm", name, i + 1), 32'(im), ev[i][11] ? 32'(imm_e) : 32'd0);
      chk($sformatf("%s c%0d op_ctl", name, i + 1), 32'(oc), ev[i][11] ? 32'(op_e) : 32'd0);
      $display("%s cycle k+%0d strobes=%03h reg_sel=%0d imm=%0d op_ctl=%0d", name, i + 1, v, rs, im, oc);
      @(negedge clk);
    end
  endtask

  int dcnt;
  int dpos [3];
  int bcnt;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; instr0 = 16'h0; instr1 = 16'h0;
    @(negedge clk);
    chk("reset strobes1", 32'(vec1), 32'd0);
    chk("reset strobes0", 32'(vec0), 32'd0);
    chk("reset reg_sel1", 32'(reg_sel1), 32'd0);
    chk("reset op_ctl1", 32'(op_ctl1), 32'd0);
    rst = 1'b0;

    // op 9, p1=2, p2=5, register operand B
    ev = '{V_FETCH, V_LD_A, V_GAP, V_RDB_R, V_LDB_R, V_EXEC, V_DRV, V_WB, V_DONE, V_IDLE};
    er = '{6'd2, 6'd2, 6'd0, 6'd5, 6'd5, 6'd0, 6'd2, 6'd2, 6'd0, 6'd0};
    run_seq(1'b0, 16'h9085, 5'd0, 3'd0, "reg_9085");

    // op 15, immediate operand 7
    ev = '{V_FETCH, V_LD_A, V_GAP, V_RDB_I, V_LDB_I, V_EXEC, V_DRV, V_WB, V_DONE, V_IDLE};
    er = '{6'd2, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd2, 6'd0, 6'd0};
    run_seq(1'b0, 16'hF0A7, 5'd7, 3'd6, "imm_F0A7");

    // illegal opcode 5: single DONE cycle with illegal
    ev = '{V_ILL, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE, V_IDLE};
    er = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    run_seq(1'b0, 16'h5085, 5'd0, 3'd0, "ill_5085");

    // reset asserted during EXEC clears outputs without a clock edge
    start1 = 1'b1; instr1 = 16'hF0A7;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset exec strobes", 32'(vec1), 32'(V_EXEC));
    chk("pre-reset imm", 32'(imm1), 32'd7);
    rst = 1'b1;
    #1;
    chk("mid reset strobes", 32'(vec1), 32'd0);
    chk("mid reset imm", 32'(imm1), 32'd0);
    chk("mid reset op_ctl", 32'(op_ctl1), 32'd0);
    chk("mid reset reg_sel", 32'(reg_sel1), 32'd0);
    $display("reset during EXEC strobes=%03h imm=%0d op_ctl=%0d", vec1, imm1, op_ctl1);
    @(negedge clk);
    rst = 1'b0;

    // first start after reset release: op 10, p1=3, p2=3
    ev = '{V_FETCH, V_LD_A, V_GAP, V_RDB_R, V_LDB_R, V_EXEC, V_DRV, V_WB, V_DONE, V_IDLE};
    er = '{6'd3, 6'd3, 6'd0, 6'd3, 6'd3, 6'd0, 6'd3, 6'd3, 6'd0, 6'd0};
    run_seq(1'b0, 16'hA0C3, 5'd0, 3'd1, "post_rst_A0C3");

    // SETTLE=0, IMM_EN=0 build: p2 MSB is just a register number
    ev = '{V_FETCH, V_LD_A, V_RDB_R, V_LDB_R, V_EXEC, V_DRV, V_WB, V_DONE, V_IDLE, V_IDLE};
    er = '{6'd2, 6'd2, 6'd39, 6'd39, 6'd0, 6'd2, 6'd2, 6'd0, 6'd0, 6'd0};
    run_seq(1'b1, 16'hF0A7, 5'd0, 3'd6, "s0_F0A7");

    // start held high: done every 10 cycles
    start1 = 1'b1; instr1 = 16'h9085;
    dcnt = 0; dpos = '{-1, -1, -1};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done1) begin
        if (dcnt < 3) dpos[dcnt] = c;
        dcnt++;
        $display("back-to-back done at cycle k+%0d", c);
      end
    end
    start1 = 1'b0;
    chk("b2b done count", 32'(dcnt), 32'd3);
    chk("b2b done0 pos", 32'(dpos[0]), 32'd9);
    chk("b2b done1 pos", 32'(dpos[1]), 32'd19);
    chk("b2b done2 pos", 32'(dpos[2]), 32'd29);
    bcnt = 0;
    while (busy1 && bcnt < 20) begin
      @(negedge clk);
      bcnt++;
    end
    chk("b2b drain bound", 32'(busy1), 32'd0);

    // start pulse while busy is ignored
    start1 = 1'b1; instr1 = 16'h9085;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1; instr1 = 16'h5085;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignore done at k+9", 32'(vec1), 32'(V_DONE));
    chk("ignore op_ctl", 32'(op_ctl1), 32'd0);
    for (int c = 10; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("ignore idle k+%0d", c), 32'(vec1), 32'd0);
      $display("ignored-start cycle k+%0d strobes=%03h", c, vec1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
